fcapture: RTL and testbench
===========================

Name: fcapture

Overview:
- Video capture engine: the receive-side counterpart of the framebuffer display driver.
- Samples an incoming RGB pixel stream (vsyn/hsyn/de), quantises each pixel to a 4-bit palette index and packs 16 pixels per 64-bit word.
- Writes the words into the graphics frame store over the hid write bus, using the same word/nibble layout the display driver reads back.
- Sits beside the CPU on the hid bus; an external arbiter grants it write cycles.

Parameters:
- LINE_WORDS, 32, 64-bit words per stored line (32 words = 512 pixels); same meaning as the display's ghlimit.
- MAX_LINES, 768, number of lines stored per frame; later lines are ignored.
- FIFO_DEPTH, 4, write-buffer depth in words; must be a power of two.

Ports:
- clk_i  in  1  system clock; pixel stream is synchronous to it
- rst_ni  in  1  asynchronous active-low reset
- vsyn  in  1  vertical sync, active high
- hsyn  in  1  horizontal sync, active high; informational only, not used by the logic
- de  in  1  pixel valid / data enable
- red, green, blue  in  8 each  pixel colour
- arm  in  1  one-cycle pulse: capture the next complete frame
- abort  in  1  one-cycle pulse: stop capture and discard buffered words
- hid_gnt  in  1  arbiter grants the bus this cycle
- hid_en  out  1  write strobe
- hid_we  out  8  byte enables; 8'hFF whenever hid_en=1, else 0
- hid_addr  out  20  byte address; bit19=1, [18:3]=word index, [2:0]=0
- hid_wrdata  out  64  packed pixels
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  sticky; set on frame completion, cleared by arm
- overflow  out  1  sticky; a word was dropped because the FIFO was full; cleared by arm
- lines_captured  out  10  lines written in the current or last frame

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty.
- Pixel index = {r[7], g[7], b[7], r[6]|g[6]|b[6]}.
- Packing: pixel n of a word (n = 0..15) occupies bits [4n+3:4n].
- States:
  - IDLE: wait for arm, then go to WAIT_VS.
  - WAIT_VS: wait for a vsyn rising edge (registered previous value), then go to CAPTURE with line=0, word=0, nib=0.
  - CAPTURE:
    - On de=1: if line<MAX_LINES and word<LINE_WORDS, place the pixel in the shift word. nib==15 completes the word. Pixels beyond LINE_WORDS*16 in a line are discarded.
    - On a de falling edge with nib!=0: the partial word completes zero-padded in its upper nibbles.
    - Every de falling edge: line++ (saturates at MAX_LINES); lines_captured <= min(line+1, MAX_LINES); word=0, nib=0.
    - A vsyn rising edge while in CAPTURE goes to DRAIN.
  - DRAIN: wait for FIFO empty, then go to DONE and set done.
  - DONE: behaves as IDLE; arm restarts at WAIT_VS and clears done, overflow and lines_captured.
- Completed word: push {data, word index = line*LINE_WORDS + word} into the FIFO, then word++.
  - FIFO full: drop the word and set overflow; word still increments, so addresses of later words are unaffected.
- Bus side:
  - hid_en=1 in a cycle where the FIFO is non-empty and hid_gnt=1. Address and data come from the FIFO head, registered, so they are valid in the same cycle as hid_en.
  - Pop occurs in that cycle. One write per cycle maximum.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
- abort, any state: FIFO flushed, hid_en forced 0 the next cycle, state IDLE, done unchanged.
- arm while busy: ignored. abort and arm in the same cycle: abort wins.
- Latency: the 16th pixel at cycle t gives hid_en at t+2 at the earliest, when hid_gnt=1 and the FIFO was empty.
- Word index arithmetic is 16 bits; MAX_LINES*LINE_WORDS must be at most 65536.

Test Plan:
- Single frame: arm; vsyn pulse; 2 lines of 32 de pixels, all red=8'hC0, green=0, blue=0; vsyn; hid_gnt=1 -> 4 writes, data 64'h9999_9999_9999_9999, hid_addr 20'h80000, 20'h80008, 20'h80100, 20'h80108; done=1; lines_captured=2.
- Partial word: 5 pixels of white (FF,FF,FF) then de falls -> one write, data 64'h0000_0000_000F_FFFF.
- Overflow: hid_gnt=0, 96 pixels (6 words, FIFO_DEPTH=4) -> overflow=1; then hid_gnt=1 -> 4 writes only, to word indices 0..3; 6th word of the next line lands at index LINE_WORDS+5.
- Line clipping: 600 pixels in one line with LINE_WORDS=32 -> exactly 32 writes, last at hid_addr 20'h800F8.
- Abort: abort mid-line with 3 words queued and hid_gnt=0 -> busy=0 next cycle; no further hid_en after hid_gnt=1.
- Async reset: assert rst_ni=0 during CAPTURE between clock edges -> all outputs 0 immediately, not at the next edge; after release, no writes until arm.

Source files
------------

// File: rtl/fcapture_if.sv
// Write-side bus between the capture engine and the frame store arbiter.
// The master drives the write strobe, address and data; the slave grants cycles.
interface fcapture_if;
    logic        hid_gnt;
    logic        hid_en;
    logic [7:0]  hid_we;
    logic [19:0] hid_addr;
    logic [63:0] hid_wrdata;

    modport master (
        input  hid_gnt,
        output hid_en,
        output hid_we,
        output hid_addr,
        output hid_wrdata
    );

    modport slave (
        output hid_gnt,
        input  hid_en,
        input  hid_we,
        input  hid_addr,
        input  hid_wrdata
    );
endinterface

// File: rtl/fcapture.sv
// Video capture engine: quantises an RGB pixel stream to 4-bit palette indices,
// packs 16 per 64-bit word and writes one armed frame into the frame store.
module fcapture #(
    parameter int LINE_WORDS = 32,
    parameter int MAX_LINES  = 768,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        vsyn,
    input  logic        hsyn,
    input  logic        de,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    input  logic        arm,
    input  logic        abort,
    fcapture_if.master  hid,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [9:0]  lines_captured
);

    localparam int LINE_CW = $clog2(MAX_LINES + 1);
    localparam int WORD_CW = $clog2(LINE_WORDS + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [LINE_CW-1:0] MAX_L     = LINE_CW'(MAX_LINES);
    localparam logic [LINE_CW-1:0] LINE_ONE  = LINE_CW'(1'b1);
    localparam logic [LINE_CW-1:0] LINE_ZERO = LINE_CW'(1'b0);
    localparam logic [WORD_CW-1:0] WORDS_L   = WORD_CW'(LINE_WORDS);
    localparam logic [WORD_CW-1:0] WORD_ONE  = WORD_CW'(1'b1);
    localparam logic [WORD_CW-1:0] WORD_ZERO = WORD_CW'(1'b0);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0]   PTR_ZERO  = PTR_W'(1'b0);
    localparam logic [CNT_W-1:0]   DEPTH_L   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(1'b0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_VS = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]         state_r, state_nxt_s;
    logic               busy_r, done_r, ovf_r;
    logic [9:0]         lines_r;
    logic               vs_prev_r, de_prev_r;
    logic [63:0]        acc_r, acc_nxt_s, push_data_s;
    logic [3:0]         nib_r, nib_nxt_s;
    logic [WORD_CW-1:0] word_r, word_nxt_s;
    logic [LINE_CW-1:0] line_r, line_nxt_s;
    logic [3:0]         pix_s;
    logic [15:0]        idx_s;
    logic               vs_rise_s, de_fall_s, in_window_s, cap_s, start_s, arm_ok_s;
    logic               push_s, pop_s, wr_s, drop_s, full_s, empty_s;
    logic [63:0]        data_mem_r [FIFO_DEPTH];
    logic [15:0]        idx_mem_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               en_r;
    logic [7:0]         we_r;
    logic [19:0]        addr_r;
    logic [63:0]        wrdata_r;
    logic               unused_s;

    // Colour MSBs select the hue, the OR of the next bits marks "bright"
    assign pix_s       = {red[7], green[7], blue[7], red[6] | green[6] | blue[6]};
    assign unused_s    = ^{hsyn, red[5:0], green[5:0], blue[5:0]};
    assign vs_rise_s   = vsyn & ~vs_prev_r;
    assign de_fall_s   = de_prev_r & ~de;
    assign in_window_s = (line_r < MAX_L) && (word_r < WORDS_L);
    assign cap_s       = (state_r == S_CAPTURE) && !abort;
    assign start_s     = (state_r == S_WAIT_VS) && vs_rise_s && !abort;
    assign arm_ok_s    = arm && !abort && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign idx_s       = 16'(line_r * LINE_WORDS) + 16'(word_r);

    assign full_s  = (count_r == DEPTH_L);
    assign empty_s = (count_r == CNT_ZERO);
    assign pop_s   = !empty_s && hid.hid_gnt && !abort;
    // A full FIFO still accepts a word when its head leaves in the same cycle
    assign wr_s    = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    assign busy           = busy_r;
    assign done           = done_r;
    assign overflow       = ovf_r;
    assign lines_captured = lines_r;
    assign hid.hid_en     = en_r;
    assign hid.hid_we     = we_r;
    assign hid.hid_addr   = addr_r;
    assign hid.hid_wrdata = wrdata_r;

    // Next-state logic; abort overrides every state
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (arm) state_nxt_s = S_WAIT_VS;
                    else     state_nxt_s = state_r;
                end
                S_WAIT_VS: begin
                    if (vs_rise_s) state_nxt_s = S_CAPTURE;
                    else           state_nxt_s = state_r;
                end
                S_CAPTURE: begin
                    if (vs_rise_s) state_nxt_s = S_DRAIN;
                    else           state_nxt_s = state_r;
                end
                S_DRAIN: begin
                    if (empty_s) state_nxt_s = S_DONE;
                    else         state_nxt_s = state_r;
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Pixel packer: builds the shift word and decides when a word completes
    always_comb begin
        acc_nxt_s   = acc_r;
        nib_nxt_s   = nib_r;
        word_nxt_s  = word_r;
        line_nxt_s  = line_r;
        push_s      = 1'b0;
        push_data_s = acc_r;
        if (start_s) begin
            acc_nxt_s  = 64'd0;
            nib_nxt_s  = 4'd0;
            word_nxt_s = WORD_ZERO;
            line_nxt_s = LINE_ZERO;
        end else if (cap_s && de && in_window_s) begin
            acc_nxt_s[{nib_r, 2'b00} +: 4] = pix_s;
            if (nib_r == 4'hF) begin
                push_s      = 1'b1;
                push_data_s = acc_nxt_s;
                acc_nxt_s   = 64'd0;
                nib_nxt_s   = 4'd0;
                word_nxt_s  = word_r + WORD_ONE;
            end else begin
                nib_nxt_s = nib_r + 4'd1;
            end
        end else if (cap_s && de_fall_s) begin
            // Upper nibbles of a partial word are already zero
            push_s     = (nib_r != 4'd0);
            acc_nxt_s  = 64'd0;
            nib_nxt_s  = 4'd0;
            word_nxt_s = WORD_ZERO;
            if (line_r == MAX_L) line_nxt_s = line_r;
            else                 line_nxt_s = line_r + LINE_ONE;
        end else begin
            push_s = 1'b0;
        end
    end

    // Control state, capture counters and sticky status
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= S_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
            lines_r   <= 10'd0;
            vs_prev_r <= 1'b0;
            de_prev_r <= 1'b0;
            acc_r     <= 64'd0;
            nib_r     <= 4'd0;
            word_r    <= WORD_ZERO;
            line_r    <= LINE_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s == S_WAIT_VS) || (state_nxt_s == S_CAPTURE) ||
                         (state_nxt_s == S_DRAIN);
            vs_prev_r <= vsyn;
            de_prev_r <= de;
            acc_r     <= acc_nxt_s;
            nib_r     <= nib_nxt_s;
            word_r    <= word_nxt_s;
            line_r    <= line_nxt_s;
            if (arm_ok_s) begin
                done_r  <= 1'b0;
                ovf_r   <= 1'b0;
                lines_r <= 10'd0;
            end else begin
                if ((state_r == S_DRAIN) && empty_s && !abort) done_r <= 1'b1;
                if (drop_s) ovf_r <= 1'b1;
                if (cap_s && de_fall_s) lines_r <= 10'(line_nxt_s);
            end
        end
    end

    // Write-buffer pointers and occupancy; abort discards everything queued
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (abort) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_s)  wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Write-buffer storage: packed data plus its frame-store word index
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 64'd0;
                idx_mem_r[i]  <= 16'd0;
            end
        end else if (wr_s) begin
            data_mem_r[wr_ptr_r] <= push_data_s;
            idx_mem_r[wr_ptr_r]  <= idx_s;
        end
    end

    // Bus write register: the FIFO head is presented together with its strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_r     <= 1'b0;
            we_r     <= 8'h00;
            addr_r   <= 20'h00000;
            wrdata_r <= 64'd0;
        end else if (pop_s) begin
            en_r     <= 1'b1;
            we_r     <= 8'hFF;
            addr_r   <= {1'b1, idx_mem_r[rd_ptr_r], 3'b000};
            wrdata_r <= data_mem_r[rd_ptr_r];
        end else begin
            en_r <= 1'b0;
            we_r <= 8'h00;
        end
    end

endmodule

// File: tb/tb_fcapture.sv
// Randomised bench for fcapture: a frame-level reference model queues the
// expected frame-store writes, and a monitor matches every bus write against it.
module tb_fcapture;
    localparam int LW = 32;
    localparam int ML = 768;
    localparam int FD = 4;

    typedef struct packed {
        logic [19:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic        vsyn   = 1'b0;
    logic        hsyn   = 1'b0;
    logic        de     = 1'b0;
    logic [7:0]  red    = 8'd0;
    logic [7:0]  green  = 8'd0;
    logic [7:0]  blue   = 8'd0;
    logic        arm    = 1'b0;
    logic        abort  = 1'b0;
    logic        busy, done, overflow;
    logic [9:0]  lines_captured;

    int          checks   = 0;
    int          failures = 0;
    int          gnt_mode = 0;
    int          mline    = 0;
    logic [19:0] last_addr = 20'd0;
    wr_t         exp_q[$];
    wr_t         mon_e;

    fcapture_if hid();

    fcapture #(.LINE_WORDS(LW), .MAX_LINES(ML), .FIFO_DEPTH(FD)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .vsyn           (vsyn),
        .hsyn           (hsyn),
        .de             (de),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .arm            (arm),
        .abort          (abort),
        .hid            (hid),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .lines_captured (lines_captured)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Arbiter grant: 0 = never, 1 = always, 2 = random with 3/4 probability
    initial begin
        hid.hid_gnt = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            hid.hid_gnt = (gnt_mode == 1) || ((gnt_mode == 2) && ($urandom_range(0, 3) != 0));
        end
    end

    // Monitor: every write must match the oldest outstanding expectation
    always @(negedge clk_i) begin
        if (rst_ni && hid.hid_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         hid.hid_addr, hid.hid_wrdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(hid.hid_addr), 64'(mon_e.addr));
                check("wr_data", hid.hid_wrdata, mon_e.data);
                check("wr_we", 64'(hid.hid_we), 64'hFF);
                last_addr = hid.hid_addr;
            end
        end
    end

    function automatic logic [3:0] pix_index(input logic [23:0] c);
        logic [7:0] r, g, b;
        {r, g, b} = c;
        return {r[7], g[7], b[7], (r[6] || g[6] || b[6])};
    endfunction

    function automatic logic [23:0] pick(input int mode);
        if (mode == 1) return 24'hC00000;
        if (mode == 2) return 24'hFFFFFF;
        return 24'($urandom);
    endfunction

    // Reference: a stored line keeps its first LW*16 pixels, 16 per word, zero padded;
    // only the first 'keep' words of the line reach the frame store
    task automatic expect_line(input int line, input logic [3:0] px[$], input int keep);
        int  n;
        wr_t e;
        n = px.size();
        if (line >= ML) return;
        if (n > LW * 16) n = LW * 16;
        for (int w = 0; w * 16 < n; w++) begin
            e.data = 64'd0;
            for (int k = 0; k < 16; k++)
                if (w * 16 + k < n) e.data[4 * k +: 4] = px[w * 16 + k];
            e.addr = 20'h80000 | 20'((line * LW + w) * 8);
            if (w < keep) exp_q.push_back(e);
        end
    endtask

    task automatic drive_rgb(input logic [23:0] q[$]);
        foreach (q[i]) begin
            de = 1'b1;
            {red, green, blue} = q[i];
            tick();
        end
    endtask

    task automatic send_line(input int n, input int mode, input int gap, input int keep);
        logic [23:0] rgb_q[$];
        logic [3:0]  px_q[$];
        logic [23:0] c;
        for (int i = 0; i < n; i++) begin
            c = pick(mode);
            rgb_q.push_back(c);
            px_q.push_back(pix_index(c));
        end
        expect_line(mline, px_q, keep);
        mline++;
        drive_rgb(rgb_q);
        de = 1'b0;
        hsyn = 1'b1;
        tick();
        hsyn = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic vs_pulse();
        vsyn = 1'b1;
        tick();
        vsyn = 1'b0;
    endtask

    task automatic start_frame();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("armed_busy", 64'(busy), 64'd1);
        check("armed_done_clear", 64'(done), 64'd0);
        repeat (2) tick();
        vs_pulse();
        repeat (2) tick();
        mline = 0;
    endtask

    task automatic end_frame(input int exp_lines, input logic exp_ovf);
        repeat (3) tick();
        vs_pulse();
        for (int i = 0; i < 5000 && !done; i++) tick();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done", 64'(done), 64'd1);
        check("lines_captured", 64'(lines_captured), 64'(exp_lines));
        check("busy_after_done", 64'(busy), 64'd0);
        check("overflow", 64'(overflow), 64'(exp_ovf));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_lines"}, 64'(lines_captured), 64'd0);
        check({tag, "_hid_en"}, 64'(hid.hid_en), 64'd0);
        check({tag, "_hid_we"}, 64'(hid.hid_we), 64'd0);
        check({tag, "_hid_addr"}, 64'(hid.hid_addr), 64'd0);
        check({tag, "_hid_wrdata"}, hid.hid_wrdata, 64'd0);
    endtask

    initial begin
        logic [23:0] raw_q[$];

        repeat (3) tick();
        check_all_zero("reset");
        rst_ni = 1'b1;
        tick();

        // Two lines of bright red
        gnt_mode = 1;
        start_frame();
        send_line(32, 1, 4, 1000);
        send_line(32, 1, 4, 1000);
        end_frame(2, 1'b0);

        // Partial word of white
        start_frame();
        send_line(5, 2, 4, 1000);
        end_frame(1, 1'b0);

        // Overflow with the bus withheld, then a normal line
        gnt_mode = 0;
        start_frame();
        send_line(96, 0, 4, FD);
        check("overflow_set", 64'(overflow), 64'd1);
        gnt_mode = 1;
        repeat (8) tick();
        send_line(96, 0, 4, 1000);
        end_frame(2, 1'b1);

        // Line longer than the stored width
        start_frame();
        send_line(600, 0, 4, 1000);
        end_frame(1, 1'b0);
        check("clip_last_addr", 64'(last_addr), 64'h800F8);

        // Random lines under a random grant
        gnt_mode = 2;
        for (int f = 0; f < 3; f++) begin
            int nl;
            nl = $urandom_range(1, 6);
            start_frame();
            for (int l = 0; l < nl; l++)
                send_line($urandom_range(1, 80), 0, $urandom_range(2, 5), 1000);
            end_frame(nl, 1'b0);
        end

        // More lines than the frame holds
        gnt_mode = 1;
        start_frame();
        for (int l = 0; l < ML + 2; l++) send_line(1, 0, 2, 1000);
        end_frame(ML, 1'b0);

        // Abort with three words queued and no grant
        gnt_mode = 0;
        start_frame();
        raw_q.delete();
        for (int i = 0; i < 50; i++) raw_q.push_back(pick(0));
        drive_rgb(raw_q);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        de = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hid_en", 64'(hid.hid_en), 64'd0);
        gnt_mode = 1;
        repeat (20) tick();
        check("abort_done_kept", 64'(done), 64'd0);
        check("abort_no_writes", 64'(exp_q.size()), 64'd0);

        // abort beats arm in the same cycle
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        check("abort_beats_arm", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a line
        start_frame();
        send_line(40, 0, 3, 1000);
        repeat (6) tick();
        check("lines_before_reset", 64'(lines_captured), 64'd1);
        raw_q.delete();
        for (int i = 0; i < 10; i++) raw_q.push_back(pick(0));
        drive_rgb(raw_q);
        #3;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk_i);
        #1;
        de = 1'b0;
        rst_ni = 1'b1;
        tick();
        vs_pulse();
        repeat (2) tick();
        raw_q.delete();
        for (int i = 0; i < 40; i++) raw_q.push_back(pick(0));
        drive_rgb(raw_q);
        de = 1'b0;
        repeat (3) tick();
        vs_pulse();
        repeat (20) tick();
        check("post_reset_idle", 64'(busy), 64'd0);
        check("post_reset_no_writes", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
